// File: rtl/asteroid_pkg.sv
// Shared constants and types for the asteroid game blocks.
// Pure declarations; no logic, no latency.
// No flow control.
package asteroid_pkg;
    localparam int NUM_SLOTS = 3;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        LAUNCH   = 2'd2,
        COOLDOWN = 2'd3
    } launch_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Debounce a raw button and produce a single-pixpulse rise strobe.
// Latency: level accepted TICKS pixpulses after the change sample; rise registered alongside stable.
// No backpressure; advances only on pixpulse.
module btn_debounce #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pixpulse,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam logic [3:0] TICKS_W = 4'(TICKS);

    logic       last;
    logic [3:0] cnt;
    logic       released;

    // released blocks a rise until a low level has been accepted, so a
    // button held through reset needs a real release before it can fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b0;
            cnt      <= 4'd0;
            stable   <= 1'b0;
            rise     <= 1'b0;
            released <= 1'b0;
        end else if (pixpulse) begin
            rise <= 1'b0;
            if (raw != last) begin
                last <= raw;
                cnt  <= 4'd0;
            end else if (cnt != TICKS_W) begin
                cnt <= cnt + 4'd1;
                if (cnt + 4'd1 == TICKS_W) begin
                    stable <= last;
                    rise   <= last & ~stable & released;
                    if (!last) begin
                        released <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/bullet_launcher.sv
// Turns debounced fire presses into one-hot launch strobes for free bullet slots.
// Latency: fire pulses 2 pixpulses after the debounced press (ARM, LAUNCH); then COOLDOWN_FRAMES moves of lockout.
// No backpressure: presses arriving with no free slot or during cooldown are dropped.
module bullet_launcher
    import asteroid_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int DEBOUNCE_TICKS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pixpulse,
    input  logic                 move,
    input  logic                 fire_btn,
    input  logic [9:0]           ship_x,
    input  logic [9:0]           ship_y,
    input  logic [NUM_SLOTS-1:0] slot_broken,
    output logic [NUM_SLOTS-1:0] fire,
    output logic [9:0]           fire_x,
    output logic [9:0]           fire_y,
    output logic [1:0]           bullet_count,
    output logic                 ready
);
    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_FRAMES);

    launch_state_t       state, state_nxt;
    logic [NUM_SLOTS-1:0] occ;
    logic [1:0]           sel;
    logic [1:0]           low_free;
    logic [1:0]           occ_count;
    logic [3:0]           cd;
    logic                 any_free;
    logic                 btn_stable;
    logic                 btn_rise;

    btn_debounce #(
        .TICKS(DEBOUNCE_TICKS)
    ) u_fire_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .pixpulse (pixpulse),
        .raw      (fire_btn),
        .stable   (btn_stable),
        .rise     (btn_rise)
    );

    assign any_free = ~&occ;

    always_comb begin
        low_free = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                low_free = 2'(i);
            end
        end
    end

    always_comb begin
        occ_count = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occ_count = occ_count + 2'(occ[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (pixpulse) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (btn_rise && btn_stable && any_free) state_nxt = ARM;
            ARM:      state_nxt = LAUNCH;
            LAUNCH:   state_nxt = COOLDOWN;
            COOLDOWN: if (cd == 4'd0 || (move && cd == 4'd1)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            fire[i] = (state == LAUNCH) && (sel == 2'(i));
        end
    end

    // Set beats clear: a slot keeps reporting broken until it has seen its fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ          <= '0;
            sel          <= 2'd0;
            fire_x       <= 10'd0;
            fire_y       <= 10'd0;
            cd           <= 4'd0;
            bullet_count <= 2'd0;
            ready        <= 1'b0;
        end else if (pixpulse) begin
            occ          <= (occ & ~slot_broken) | fire;
            bullet_count <= occ_count;
            ready        <= (state == IDLE) && any_free && (cd == 4'd0);
            if (state == ARM) begin
                fire_x <= ship_x;
                fire_y <= ship_y;
                sel    <= low_free;
            end
            if (state == LAUNCH) begin
                cd <= CD_LOAD;
            end else if (state == COOLDOWN && move && cd != 4'd0) begin
                cd <= cd - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_bullet_launcher.sv
// Directed scenario bench for bullet_launcher with an emulated set of bullet slots.
module tb_bullet_launcher;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pixpulse;
    logic       move;
    logic       fire_btn;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic [2:0] slot_broken;
    logic [2:0] fire;
    logic [9:0] fire_x;
    logic [9:0] fire_y;
    logic [1:0] bullet_count;
    logic       ready;

    int         vectors = 0;
    int         errors  = 0;
    int         pulses  = 0;
    logic [2:0] last_fire = 3'b000;
    logic [2:0] alive = 3'b000;

    always #5 clk = ~clk;

    bullet_launcher #(
        .COOLDOWN_FRAMES (8),
        .DEBOUNCE_TICKS  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixpulse     (pixpulse),
        .move         (move),
        .fire_btn     (fire_btn),
        .ship_x       (ship_x),
        .ship_y       (ship_y),
        .slot_broken  (slot_broken),
        .fire         (fire),
        .fire_x       (fire_x),
        .fire_y       (fire_y),
        .bullet_count (bullet_count),
        .ready        (ready)
    );

    // One clock; bullets come alive after seeing their fire strobe.
    task automatic tick(input logic mv);
        logic [2:0] f;
        move = mv;
        f = fire & {3{pixpulse}};
        @(posedge clk);
        #1;
        if (|fire) begin
            pulses++;
            last_fire = fire;
        end
        alive = alive | f;
        slot_broken = ~alive;
    endtask

    task automatic ticks(input int n, input logic mv);
        for (int i = 0; i < n; i++) tick(mv);
    endtask

    task automatic kill(input logic [2:0] mask);
        alive = alive & ~mask;
        slot_broken = ~alive;
    endtask

    // Release the button and run out the cooldown.
    task automatic settle();
        fire_btn = 1'b0;
        ticks(10, 1'b1);
        ticks(6, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pixpulse = 1'b1; move = 1'b0; fire_btn = 1'b0;
        ship_x = 10'd0; ship_y = 10'd0; alive = 3'b000; slot_broken = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (fire !== 3'b000) begin errors++; $display("FAIL reset_fire: got %b expected 000", fire); end
        vectors++; if (fire_x !== 10'd0) begin errors++; $display("FAIL reset_fire_x: got %0d expected 0", fire_x); end
        vectors++; if (fire_y !== 10'd0) begin errors++; $display("FAIL reset_fire_y: got %0d expected 0", fire_y); end
        vectors++; if (bullet_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bullet_count); end
        rst_n = 1'b1;
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b expected 0", ready); end
        tick(1'b0);
        vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", ready); end
        ticks(6, 1'b0);
    endtask

    task automatic test_first_shot();
        ship_x = 10'd320; ship_y = 10'd240;
        fire_btn = 1'b1;
        ticks(6, 1'b0);
        vectors++; if (fire !== 3'b000) begin errors++; $display("FAIL first_latency_early: got %b expected 000", fire); end
        tick(1'b0);
        vectors++; if (fire !== 3'b001) begin errors++; $display("FAIL first_fire: got %b expected 001", fire); end
        vectors++; if (fire_x !== 10'd320) begin errors++; $display("FAIL first_fire_x: got %0d expected 320", fire_x); end
        vectors++; if (fire_y !== 10'd240) begin errors++; $display("FAIL first_fire_y: got %0d expected 240", fire_y); end
        fire_btn = 1'b0;
        ticks(2, 1'b0);
        vectors++; if (bullet_count !== 2'd1) begin errors++; $display("FAIL first_count: got %0d expected 1", bullet_count); end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL first_ready_cooldown: got %b expected 0", ready); end
        settle();
        vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL first_ready_idle: got %b expected 1", ready); end
    endtask

    task automatic test_three_shots();
        ship_x = 10'd100; ship_y = 10'd50;
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b010) begin errors++; $display("FAIL second_fire: got %b expected 010", fire); end
        vectors++; if (fire_x !== 10'd100) begin errors++; $display("FAIL second_fire_x: got %0d expected 100", fire_x); end
        settle();
        ship_x = 10'd639; ship_y = 10'd479;
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b100) begin errors++; $display("FAIL third_fire: got %b expected 100", fire); end
        vectors++; if (fire_y !== 10'd479) begin errors++; $display("FAIL third_fire_y: got %0d expected 479", fire_y); end
        fire_btn = 1'b0;
        ticks(2, 1'b0);
        vectors++; if (bullet_count !== 2'd3) begin errors++; $display("FAIL three_count: got %0d expected 3", bullet_count); end
        settle();
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ready); end
    endtask

    task automatic test_full_drop();
        ship_x = 10'd5; ship_y = 10'd6;
        pulses = 0;
        fire_btn = 1'b1;
        ticks(12, 1'b0);
        fire_btn = 1'b0;
        ticks(8, 1'b0);
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL full_drop_pulses: got %0d expected 0", pulses); end
        vectors++; if (fire_x !== 10'd639) begin errors++; $display("FAIL full_hold_fire_x: got %0d expected 639", fire_x); end
        kill(3'b010);
        ticks(2, 1'b0);
        vectors++; if (bullet_count !== 2'd2) begin errors++; $display("FAIL broken1_count: got %0d expected 2", bullet_count); end
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b010) begin errors++; $display("FAIL refill_fire: got %b expected 010", fire); end
        vectors++; if (fire_x !== 10'd5) begin errors++; $display("FAIL refill_fire_x: got %0d expected 5", fire_x); end
        settle();
    endtask

    task automatic test_cooldown_window();
        kill(3'b111);
        ticks(2, 1'b0);
        vectors++; if (bullet_count !== 2'd0) begin errors++; $display("FAIL cleared_count: got %0d expected 0", bullet_count); end
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b001) begin errors++; $display("FAIL cd_first_fire: got %b expected 001", fire); end
        fire_btn = 1'b0;
        pulses = 0;
        ticks(6, 1'b0);
        fire_btn = 1'b1;
        ticks(6, 1'b1);
        fire_btn = 1'b0;
        ticks(2, 1'b1);
        ticks(6, 1'b0);
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL cd_drop_pulses: got %0d expected 0", pulses); end
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b010) begin errors++; $display("FAIL cd_after_fire: got %b expected 010", fire); end
        settle();
    endtask

    task automatic test_glitch_and_hold();
        pulses = 0;
        fire_btn = 1'b1;
        ticks(2, 1'b0);
        fire_btn = 1'b0;
        ticks(20, 1'b0);
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
        fire_btn = 1'b1;
        ticks(30, 1'b1);
        vectors++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
        vectors++; if (last_fire !== 3'b100) begin errors++; $display("FAIL hold_slot: got %b expected 100", last_fire); end
        fire_btn = 1'b0;
        ticks(6, 1'b0);
        vectors++; if (bullet_count !== 2'd3) begin errors++; $display("FAIL hold_count: got %0d expected 3", bullet_count); end
    endtask

    task automatic test_pixpulse_hold();
        kill(3'b010);
        ticks(2, 1'b0);
        fire_btn = 1'b1;
        ticks(3, 1'b0);
        pixpulse = 1'b0;
        ticks(20, 1'b1);
        vectors++; if (bullet_count !== 2'd2) begin errors++; $display("FAIL pix_hold_count: got %0d expected 2", bullet_count); end
        pixpulse = 1'b1;
        ticks(3, 1'b0);
        vectors++; if (fire !== 3'b000) begin errors++; $display("FAIL pix_latency_early: got %b expected 000", fire); end
        tick(1'b0);
        vectors++; if (fire !== 3'b010) begin errors++; $display("FAIL pix_fire: got %b expected 010", fire); end
        settle();
    endtask

    task automatic test_reset_cooldown();
        kill(3'b101);
        ticks(2, 1'b0);
        vectors++; if (bullet_count !== 2'd1) begin errors++; $display("FAIL pre_rst_count1: got %0d expected 1", bullet_count); end
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b001) begin errors++; $display("FAIL pre_rst_fire: got %b expected 001", fire); end
        ticks(2, 1'b0);
        vectors++; if (bullet_count !== 2'd2) begin errors++; $display("FAIL pre_rst_count2: got %0d expected 2", bullet_count); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (fire !== 3'b000) begin errors++; $display("FAIL rst_cd_fire: got %b expected 000", fire); end
        vectors++; if (fire_x !== 10'd0 || fire_y !== 10'd0) begin errors++; $display("FAIL rst_cd_pos: got %0d,%0d expected 0,0", fire_x, fire_y); end
        vectors++; if (bullet_count !== 2'd0) begin errors++; $display("FAIL rst_cd_count: got %0d expected 0", bullet_count); end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_cd_ready: got %b expected 0", ready); end
        alive = 3'b000;
        slot_broken = 3'b111;
        ticks(2, 1'b0);
        rst_n = 1'b1;
        pulses = 0;
        ticks(20, 1'b1);
        vectors++; if (pulses !== 0) begin errors++; $display("FAIL held_through_reset: got %0d pulses expected 0", pulses); end
        fire_btn = 1'b0;
        ticks(6, 1'b0);
        fire_btn = 1'b1;
        ticks(7, 1'b0);
        vectors++; if (fire !== 3'b001) begin errors++; $display("FAIL post_rst_fire: got %b expected 001", fire); end
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_shot();
        test_three_shots();
        test_full_drop();
        test_cooldown_window();
        test_glitch_and_hold();
        test_pixpulse_hold();
        test_reset_cooldown();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bullet_launcher.md
BULLET_LAUNCHER -- requirements
Module: bullet_launcher

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 8, SHALL be the number of move ticks between successive shots; legal range 1-15.
REQ-002 Parameter DEBOUNCE_TICKS, default 4, SHALL be the number of consecutive pixpulse samples the button must hold a level before it is accepted; legal range 1-15.
REQ-003 clk  input  1  system clock, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pixpulse  input  1  pixel-rate enable; all state other than reset SHALL advance only when pixpulse=1.
REQ-006 move  input  1  per-frame update strobe, one pixpulse wide; the same strobe that drives the bullet slots.
REQ-007 fire_btn  input  1  raw, undebounced fire button, active-high.
REQ-008 ship_x  input  10  current ship x-location in pixels.
REQ-009 ship_y  input  10  current ship y-location in pixels.
REQ-010 slot_broken  input  3  per-slot status from each bullet; 1 = slot inactive or destroyed.
REQ-011 fire  output  3  one-hot launch strobe per slot, one pixpulse wide.
REQ-012 fire_x  output  10  launch x-location, valid while any fire bit is high.
REQ-013 fire_y  output  10  launch y-location, valid while any fire bit is high.
REQ-014 bullet_count  output  2  number of occupied slots, 0-3.
REQ-015 ready  output  1  high when the block is in IDLE, at least one slot is free, and no cooldown is pending.

Function
REQ-016 Debounce: a 4-bit counter SHALL reset on every sampled level change of fire_btn; when it reaches DEBOUNCE_TICKS, btn_stable SHALL take the sampled level.
REQ-017 A shot request SHALL be the 0->1 edge of btn_stable only; holding the button SHALL NOT auto-repeat.
REQ-018 The FSM SHALL have four states: IDLE, ARM, LAUNCH and COOLDOWN.
REQ-019 IDLE->ARM on a shot request when at least one slot is free; a request with no free slot SHALL be dropped, with no queuing.
REQ-020 ARM, one pixpulse: latch ship_x/ship_y into fire_x/fire_y, and latch the lowest-index free slot into sel.
REQ-021 LAUNCH, one pixpulse: fire[sel]=1, set occ[sel], then go to COOLDOWN.
REQ-022 COOLDOWN: load a counter with COOLDOWN_FRAMES, decrement it on each move strobe, and return to IDLE when it reaches 0.
REQ-023 Occupancy occ[2:0]: bit i SHALL set on fire[i] and clear on the pixpulse where slot_broken[i]=1 and fire[i]=0.
REQ-024 Simultaneous fire[i] and slot_broken[i]=1: set SHALL win, because the slot reports broken until it sees fire.
REQ-025 bullet_count SHALL equal popcount(occ) and SHALL be registered, updating one pixpulse after occ changes.
REQ-026 If the selected slot becomes occupied during ARM, LAUNCH SHALL still fire the slot latched in sel; occupancy is changed only by this block, so this case cannot occur.
REQ-027 fire_x/fire_y SHALL hold their latched value until the next ARM.
REQ-028 With pixpulse=0 all registers SHALL hold their values, and fire SHALL remain 0 outside LAUNCH.
REQ-029 Latency from the first pixpulse at which btn_stable rises to the fire pulse SHALL be exactly 2 pixpulses (ARM, LAUNCH).

Reset
REQ-030 Asynchronous rst_n=0 SHALL force: state=IDLE, occ=0, fire=0, fire_x=0, fire_y=0, bullet_count=0, cooldown counter=0, debounce counter=0, btn_stable=0.
REQ-031 ready SHALL be 1 one pixpulse after rst_n deasserts.
REQ-032 Reset asserted mid-LAUNCH or mid-COOLDOWN SHALL abort with no fire pulse emitted.
REQ-033 A button held through reset SHALL NOT fire until it is released and pressed again.

Structure
REQ-034 Shared package asteroid_pkg SHALL hold NUM_SLOTS=3, SCREEN_W=640, SCREEN_H=480, and the launcher state enum.
REQ-035 Debounce plus edge detect SHALL be the sub-module btn_debounce (ports: clk, rst_n, pixpulse, raw, stable, rise), reused for the other buttons.
REQ-036 Lowest-free-slot select and popcount SHALL be combinational logic inside bullet_launcher.

Verification
REQ-037 Reset, then press fire_btn with ship=(320,240) and all slot_broken=1 -> fire=3'b001 two pixpulses after btn_stable rises, fire_x=320, fire_y=240, bullet_count=1.
REQ-038 Three presses, each separated by more than 8 move strobes -> fire=001, then 010, then 100; bullet_count=3; ready=0.
REQ-039 With 3 slots occupied, press -> no fire pulse; assert slot_broken[1]=1 and press again -> fire=3'b010.
REQ-040 Press twice within 8 move strobes -> exactly one fire pulse; a press after the 8th strobe fires.
REQ-041 A 2-pixpulse glitch on fire_btn with DEBOUNCE_TICKS=4 -> no fire; a held button -> exactly one fire.
REQ-042 Assert rst_n=0 during COOLDOWN with occ=3'b011 -> all outputs 0 immediately; after release, a new press fires slot 0.
